// File: rtl/holy_core_pkg.sv
// Shared types and AXI constants for the holy core memory-side blocks.
package holy_core_pkg;

    // States of the cache-line transfer engine.
    typedef enum logic [2:0] {
        FS_IDLE,
        FS_AR,
        FS_R,
        FS_AW,
        FS_W,
        FS_B,
        FS_DONE
    } fetcher_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI size encoding for a full-width beat of data_w bits.
    function automatic logic [2:0] clog2_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/holy_line_fetcher.sv
// Cache-line transfer engine: refills a line with an INCR read burst or
// writes back a line with an INCR write burst, checking every response.
//
// state   | meaning
// --------+---------------------------------------------------------
// FS_IDLE | ready for a request
// FS_AR   | read address offered, waiting for arready
// FS_R    | collecting read beats into the data array
// FS_AW   | write address offered, waiting for awready
// FS_W    | streaming array words out on the W channel
// FS_B    | waiting for the write response
// FS_DONE | one-cycle done/err report
module holy_line_fetcher
    import holy_core_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int ID_W           = 4,
    parameter int AXI_ID         = 0,
    localparam int IDX_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  fill_we,
    output logic [IDX_W-1:0]      fill_idx,
    output logic [DATA_W-1:0]     fill_data,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  done,
    output logic                  err,
    output logic [ID_W-1:0]       axi_awid,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wlast,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [ID_W-1:0]       axi_bid,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ID_W-1:0]       axi_arid,
    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [ID_W-1:0]       axi_rid,
    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    localparam int CNT_W = $clog2(WORDS_PER_LINE) + 1;
    localparam int OFF_W = $clog2(WORDS_PER_LINE * DATA_W / 8);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_LINE);

    fetcher_state_t    state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              err_acc;
    logic              beat_last;
    logic              r_hs;
    logic              r_err;

    // IDs and the low address bits are intentionally ignored.
    logic unused;
    assign unused = &{1'b0, axi_rid, axi_bid, req_addr[OFF_W-1:0]};

    assign beat_last = (cnt == LAST_CNT);
    assign r_hs      = axi_rvalid && axi_rready;
    // A beat is bad on a non-OKAY response or when rlast disagrees with the count.
    assign r_err     = (axi_rresp != AXI_RESP_OKAY) || (axi_rlast != beat_last);

    assign axi_awid    = ID_W'(AXI_ID);
    assign axi_arid    = ID_W'(AXI_ID);
    assign axi_awaddr  = addr_q;
    assign axi_araddr  = addr_q;
    assign axi_awlen   = 8'(WORDS_PER_LINE - 1);
    assign axi_arlen   = 8'(WORDS_PER_LINE - 1);
    assign axi_awsize  = clog2_size(DATA_W);
    assign axi_arsize  = clog2_size(DATA_W);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_arburst = AXI_BURST_INCR;
    assign axi_wstrb   = '1;
    assign axi_wdata   = wb_data;
    assign axi_wlast   = beat_last;

    // Beats beyond the line (slave never sent rlast) must not wrap onto word 0.
    assign fill_we   = r_hs && (cnt < FULL_CNT);
    assign fill_idx  = cnt[IDX_W-1:0];
    assign fill_data = axi_rdata;

    // Transfer sequencing with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_IDLE;
            addr_q      <= '0;
            cnt         <= '0;
            err_acc     <= 1'b0;
            req_ready   <= 1'b1;
            axi_arvalid <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_rready  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        cnt       <= '0;
                        err_acc   <= 1'b0;
                        req_ready <= 1'b0;
                        if (req_write) begin
                            axi_awvalid <= 1'b1;
                            state       <= FS_AW;
                        end else begin
                            axi_arvalid <= 1'b1;
                            state       <= FS_AR;
                        end
                    end
                end
                FS_AR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= FS_R;
                    end
                end
                FS_R: begin
                    if (axi_rvalid) begin
                        if (cnt < FULL_CNT) begin
                            cnt <= cnt + 1'b1;
                        end
                        err_acc <= err_acc | r_err;
                        if (axi_rlast) begin
                            axi_rready <= 1'b0;
                            done       <= 1'b1;
                            err        <= err_acc | r_err;
                            state      <= FS_DONE;
                        end
                    end
                end
                FS_AW: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        axi_wvalid  <= 1'b1;
                        state       <= FS_W;
                    end
                end
                FS_W: begin
                    if (axi_wready) begin
                        cnt <= cnt + 1'b1;
                        if (beat_last) begin
                            axi_wvalid <= 1'b0;
                            axi_bready <= 1'b1;
                            state      <= FS_B;
                        end
                    end
                end
                FS_B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        done       <= 1'b1;
                        err        <= err_acc | (axi_bresp != AXI_RESP_OKAY);
                        state      <= FS_DONE;
                    end
                end
                FS_DONE: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= FS_IDLE;
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_holy_line_fetcher.sv
// Self-checking bench for holy_line_fetcher: a reactive AXI slave plus a
// line-level reference model (expected words, error flag and latency).
module tb_holy_line_fetcher;

    localparam int W      = 8;
    localparam int DW     = 32;
    localparam int LINE_B = W * DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: 8 words x 32 bits
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic        fill_we;
    logic [2:0]  fill_idx;
    logic [31:0] fill_data, wb_data;
    logic        done, err;
    logic [3:0]  axi_awid, axi_bid, axi_arid, axi_rid;
    logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rlast, axi_rvalid, axi_rready;

    // Second instance: 1 word x 64 bits
    logic        s_req_valid, s_req_ready, s_req_write;
    logic [31:0] s_req_addr;
    logic        s_fill_we;
    logic [0:0]  s_fill_idx;
    logic [63:0] s_fill_data, s_wb_data;
    logic        s_done, s_err;
    logic [3:0]  s_awid, s_bid, s_arid, s_rid;
    logic [31:0] s_awaddr, s_araddr;
    logic [63:0] s_wdata, s_rdata;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [7:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rlast, s_rvalid, s_rready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wb_mem [W];
    assign wb_data   = wb_mem[fill_idx];
    assign s_wb_data = 64'h0;

    holy_line_fetcher #(.WORDS_PER_LINE(W), .DATA_W(DW), .ADDR_W(32), .ID_W(4), .AXI_ID(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .wb_data(wb_data),
        .done(done), .err(err),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    holy_line_fetcher #(.WORDS_PER_LINE(1), .DATA_W(64), .ADDR_W(32), .ID_W(4), .AXI_ID(0)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write), .req_addr(s_req_addr),
        .fill_we(s_fill_we), .fill_idx(s_fill_idx), .fill_data(s_fill_data), .wb_data(s_wb_data),
        .done(s_done), .err(s_err),
        .axi_awid(s_awid), .axi_awaddr(s_awaddr), .axi_awlen(s_awlen), .axi_awsize(s_awsize),
        .axi_awburst(s_awburst), .axi_awvalid(s_awvalid), .axi_awready(s_awready),
        .axi_wdata(s_wdata), .axi_wstrb(s_wstrb), .axi_wlast(s_wlast), .axi_wvalid(s_wvalid),
        .axi_wready(s_wready),
        .axi_bid(s_bid), .axi_bresp(s_bresp), .axi_bvalid(s_bvalid), .axi_bready(s_bready),
        .axi_arid(s_arid), .axi_araddr(s_araddr), .axi_arlen(s_arlen), .axi_arsize(s_arsize),
        .axi_arburst(s_arburst), .axi_arvalid(s_arvalid), .axi_arready(s_arready),
        .axi_rid(s_rid), .axi_rdata(s_rdata), .axi_rresp(s_rresp), .axi_rlast(s_rlast),
        .axi_rvalid(s_rvalid), .axi_rready(s_rready)
    );

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0; axi_bid = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0; axi_rid = 0;
        s_req_valid = 0; s_req_write = 0; s_req_addr = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    endtask

    // One line refill. err_beat<0 means no SLVERR; last_beat is where rlast appears.
    task automatic run_refill(input logic [31:0] addr, input int err_beat, input int last_beat,
                              input bit waits, input bit pattern);
        logic [31:0] data [W];
        logic [31:0] exp_addr;
        int beat, done_cyc, exp_cyc;
        bit ar_done, r_done, exp_err, hs;
        logic got_err;
        exp_addr = addr & ~32'(LINE_B - 1);
        exp_err  = (err_beat >= 0 && err_beat <= last_beat) || (last_beat != W - 1);
        exp_cyc  = waits ? -1 : last_beat + 3;
        for (int i = 0; i < W; i++) data[i] = pattern ? 32'hA0 + 32'(i) : $urandom;
        beat = 0; done_cyc = -1; ar_done = 0; r_done = 0; got_err = 0;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = addr;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL refill_req_ready: got %b want 1", req_ready);
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            req_valid   = 0;
            axi_arready = !ar_done && (!waits || $urandom_range(0, 1) == 1);
            if (ar_done && !r_done && beat < W) begin
                axi_rvalid = !waits || $urandom_range(0, 2) != 0;
                axi_rdata  = data[beat];
                axi_rlast  = (beat == last_beat);
                axi_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
            end else if (r_done) begin
                axi_rvalid = 1; axi_rdata = $urandom; axi_rlast = 0; axi_rresp = 0;
            end else begin
                axi_rvalid = 0;
            end
            #1;
            if (axi_arvalid && axi_arready) begin
                n_cmp++;
                if (axi_araddr !== exp_addr || axi_arlen !== 8'(W - 1) || axi_arsize !== 3'd2 ||
                    axi_arburst !== 2'b01 || axi_arid !== 4'd5) begin
                    n_bad++;
                    $display("FAIL ar_hs: addr=%h len=%0d size=%0d burst=%0d id=%0d want %h %0d 2 1 5",
                             axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, exp_addr, W - 1);
                end
                ar_done = 1;
            end
            if (r_done && axi_rvalid) begin
                n_cmp++;
                if (axi_rready !== 1'b0) begin
                    n_bad++; $display("FAIL extra_beat: rready=%b want 0 after rlast", axi_rready);
                end
            end
            hs = axi_rvalid && axi_rready && !r_done;
            if (hs || fill_we) begin
                n_cmp++;
                if (fill_we !== hs || fill_idx !== 3'(beat) || fill_data !== data[beat]) begin
                    n_bad++;
                    $display("FAIL fill_beat: we=%b idx=%0d data=%h want we=%b idx=%0d data=%h",
                             fill_we, fill_idx, fill_data, hs, beat, data[beat]);
                end
            end
            if (hs) begin
                if (beat == last_beat) r_done = 1;
                beat++;
            end
            if (done === 1'b1) begin
                done_cyc = cyc; got_err = err;
            end
        end
        axi_rvalid = 0; axi_arready = 0; axi_rlast = 0; axi_rresp = 0;
        n_cmp++;
        if (done_cyc < 0) begin
            n_bad++; $display("FAIL refill_timeout: no done within budget");
        end else begin
            if (got_err !== exp_err || beat != last_beat + 1) begin
                n_bad++;
                $display("FAIL refill_result: err=%b beats=%0d want err=%b beats=%0d",
                         got_err, beat, exp_err, last_beat + 1);
            end
            if (exp_cyc >= 0) begin
                n_cmp++;
                if (done_cyc != exp_cyc) begin
                    n_bad++; $display("FAIL refill_latency: done at %0d want %0d", done_cyc, exp_cyc);
                end
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL refill_after: done=%b ready=%b want 0 1", done, req_ready);
        end
    endtask

    // One line writeback. mode 0 = no waits, 1 = wready toggles, 2 = random waits.
    task automatic run_wb(input logic [31:0] addr, input bit pattern, input int mode, input logic [1:0] bresp);
        int wb, done_cyc, exp_cyc;
        bit aw_done, b_done, tog, exp_err;
        logic got_err, exp_last;
        for (int i = 0; i < W; i++) wb_mem[i] = pattern ? 32'hB0 + 32'(i) : $urandom;
        exp_cyc = (mode == 0) ? W + 3 : -1;
        exp_err = (bresp != 2'b00);
        wb = 0; done_cyc = -1; aw_done = 0; b_done = 0; tog = 0; got_err = 0;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = addr;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL wb_req_ready: got %b want 1", req_ready);
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            req_valid   = 0;
            tog         = !tog;
            axi_awready = !aw_done && (mode != 2 || $urandom_range(0, 1) == 1);
            axi_wready  = aw_done && wb < W &&
                          (mode == 0 || (mode == 1 && tog) || (mode == 2 && $urandom_range(0, 1) == 1));
            axi_bvalid  = (wb == W) && !b_done && (mode != 2 || $urandom_range(0, 1) == 1);
            axi_bresp   = bresp;
            #1;
            if (!aw_done && axi_wvalid) begin
                n_cmp++; n_bad++; $display("FAIL w_before_aw: wvalid=1 want 0");
            end
            if (axi_awvalid && axi_awready) begin
                n_cmp++;
                if (axi_awaddr !== (addr & ~32'(LINE_B - 1)) || axi_awlen !== 8'(W - 1) ||
                    axi_awsize !== 3'd2 || axi_awburst !== 2'b01 || axi_awid !== 4'd5) begin
                    n_bad++;
                    $display("FAIL aw_hs: addr=%h len=%0d size=%0d burst=%0d id=%0d want %h %0d 2 1 5",
                             axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
                             addr & ~32'(LINE_B - 1), W - 1);
                end
                aw_done = 1;
            end
            if (axi_wvalid && axi_wready) begin
                exp_last = (wb == W - 1);
                n_cmp++;
                if (axi_wdata !== wb_mem[wb] || axi_wlast !== exp_last || axi_wstrb !== 4'hF) begin
                    n_bad++;
                    $display("FAIL w_beat%0d: data=%h last=%b strb=%h want %h %b f",
                             wb, axi_wdata, axi_wlast, axi_wstrb, wb_mem[wb], exp_last);
                end
                wb++;
            end
            if (axi_bvalid && axi_bready) b_done = 1;
            if (done === 1'b1) begin
                done_cyc = cyc; got_err = err;
            end
        end
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
        n_cmp++;
        if (done_cyc < 0) begin
            n_bad++; $display("FAIL wb_timeout: no done within budget");
        end else begin
            if (got_err !== exp_err || wb != W) begin
                n_bad++; $display("FAIL wb_result: err=%b beats=%0d want err=%b beats=%0d", got_err, wb, exp_err, W);
            end
            if (exp_cyc >= 0) begin
                n_cmp++;
                if (done_cyc != exp_cyc) begin
                    n_bad++; $display("FAIL wb_latency: done at %0d want %0d", done_cyc, exp_cyc);
                end
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL wb_after: done=%b ready=%b want 0 1", done, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        n_cmp++;
        if ({axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready, fill_we, done, err} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: arv=%b awv=%b wv=%b br=%b rr=%b we=%b done=%b err=%b want all 0",
                     axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready, fill_we, done, err);
        end
        n_cmp++;
        if (fill_idx !== 3'd0 || s_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_cnt: idx=%0d s_ready=%b want 0 1", fill_idx, s_req_ready);
        end
        rst = 0;
    endtask

    task automatic test_reset_mid_wb();
        for (int i = 0; i < W; i++) wb_mem[i] = $urandom;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h3000_0100;
        @(posedge clk);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            req_valid = 0; axi_awready = 1; axi_wready = (cyc >= 2);
            if (cyc < 6) @(posedge clk);
        end
        #1;
        n_cmp++;
        if (axi_wvalid !== 1'b1 || fill_idx !== 3'd4) begin
            n_bad++; $display("FAIL rst_pre: wvalid=%b idx=%0d want 1 4", axi_wvalid, fill_idx);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (axi_wvalid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_abort: wvalid=%b ready=%b done=%b want 0 1 0", axi_wvalid, req_ready, done);
        end
        idle_inputs();
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || axi_wvalid !== 1'b0) begin
                n_bad++; $display("FAIL rst_no_done: done=%b wvalid=%b want 0 0", done, axi_wvalid);
            end
        end
        run_refill(32'h0000_4000, -1, W - 1, 0, 0);
    endtask

    task automatic test_single_word_64();
        logic [63:0] d;
        d = {$urandom, $urandom};
        @(negedge clk);
        s_req_valid = 1; s_req_write = 0; s_req_addr = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        s_req_valid = 0; s_arready = 1;
        #1;
        n_cmp++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h100 || s_arlen !== 8'd0 || s_arsize !== 3'd3 ||
            s_arburst !== 2'b01) begin
            n_bad++;
            $display("FAIL w1_ar: v=%b addr=%h len=%0d size=%0d burst=%0d want 1 100 0 3 1",
                     s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst);
        end
        @(negedge clk);
        s_arready = 0; s_rvalid = 1; s_rdata = d; s_rlast = 1; s_rresp = 0;
        #1;
        n_cmp++;
        if (s_fill_we !== 1'b1 || s_fill_idx !== 1'b0 || s_fill_data !== d || s_done !== 1'b0) begin
            n_bad++;
            $display("FAIL w1_fill: we=%b idx=%0d data=%h done=%b want 1 0 %h 0",
                     s_fill_we, s_fill_idx, s_fill_data, s_done, d);
        end
        @(negedge clk);
        s_rvalid = 0; s_rlast = 0;
        #1;
        n_cmp++;
        if (s_done !== 1'b1 || s_err !== 1'b0 || s_fill_we !== 1'b0) begin
            n_bad++; $display("FAIL w1_done: done=%b err=%b we=%b want 1 0 0", s_done, s_err, s_fill_we);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (s_done !== 1'b0 || s_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL w1_after: done=%b ready=%b want 0 1", s_done, s_req_ready);
        end
    endtask

    task automatic test_random();
        int eb, lb;
        logic [1:0] br;
        for (int k = 0; k < 6; k++) begin
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : W - 1;
            run_refill($urandom, eb, lb, 1, 0);
            br = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_wb($urandom, 0, 2, br);
        end
    endtask

    initial begin
        test_reset();
        run_refill(32'h0000_1234, -1, W - 1, 0, 1);      // basic refill, no waits
        run_wb(32'h2000_0040, 1, 1, 2'b00);              // writeback with toggling wready
        run_wb(32'h2000_0080, 0, 0, 2'b10);              // zero-wait writeback, SLVERR
        run_refill(32'h0000_2000, 3, W - 1, 0, 0);       // SLVERR on beat 3
        run_refill(32'h0000_3000, -1, 5, 0, 0);          // early rlast on beat 5
        run_refill(32'h0000_3040, -1, W - 1, 0, 0);      // next request still accepted
        test_reset_mid_wb();
        test_single_word_64();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
